custom_axi_ip_engine: RTL
=========================

// Module: custom_axi_ip_engine
// PURPOSE
//  Parametrised successor of the register-driven IP FSM. Takes NUM_LANES packed DATA_WIDTH
//  lanes from the register block, adds a programmable step to every lane for a programmable
//  number of iterations, then writes the result back with a single-cycle write-enable.
//  Sits between the AXI register file and the register write-back path. Reports status
//  through custom_axi_ip_pkg::status_e and sticky per-lane overflow flags.
// PARAMETERS
//  DATA_WIDTH  32  width of one lane and of the step operand
//  NUM_LANES   2   number of independent lanes packed into the data buses
//  ITER_W      8   width of the iteration count (max 2**ITER_W-1 iterations)
// PORTS
//  clk_i          in   1                     clock
//  rst_ni         in   1                     reset, asynchronous, active-low
//  ipreg_data_i   in   NUM_LANES*DATA_WIDTH  lane operands (lane l = bits [l*DW +: DW])
//  ipreg_step_i   in   DATA_WIDTH            per-iteration increment, common to all lanes
//  ipreg_iter_i   in   ITER_W                iteration count
//  enable_i       in   1                     start request, sampled only in IDLE
//  abort_i        in   1                     abort request, effective only in BUSY
//  ipreg_data_o   out  NUM_LANES*DATA_WIDTH  result, updated only in DONE, then held
//  wen_o          out  1                     result write-enable, high for exactly the DONE cycle
//  status_o       out  status_e              current state (IDLE/BUSY/DONE/ERROR)
//  busy_o         out  1                     high while state == BUSY
//  ovf_o          out  NUM_LANES             sticky per-lane carry-out flag, cleared on start
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; ipreg_data_o, wen_o, busy_o, ovf_o, the lane
//    registers and the iteration counter all 0. Reset mid-operation aborts with no wen_o.
//  - status_o and busy_o decode the state register directly. wen_o and ipreg_data_o are registered.
//  - IDLE: if enable_i=1, latch the lanes, step and iter. Clear ovf_o.
//    If iter != 0, go to BUSY. If iter == 0, go to ERROR.
//  - BUSY: each cycle, every lane <= lane + step, truncated to DATA_WIDTH.
//    A carry-out sets ovf_o[l]. The counter decrements.
//    After the iter-th add the state goes to DONE.
//    abort_i=1 goes to ERROR instead and discards the add in that cycle (abort wins over the last add).
//  - DONE (1 cycle): wen_o=1 and ipreg_data_o = the final lanes. Then go to IDLE.
//  - ERROR (1 cycle): wen_o=0 and ipreg_data_o is unchanged. Then go to IDLE. Illegal state encodings go to ERROR.
//  - Latency: enable_i sampled at edge k -> BUSY during cycles k+1..k+iter -> DONE/wen_o at cycle k+iter+1.
//    Earliest next start is sampled at cycle k+iter+2.
//  - enable_i is ignored outside IDLE. abort_i is ignored outside BUSY. Inputs need not be held after the start.
//  - Lanes are fully independent. ovf_o stays valid after DONE/ERROR until the next start.
// CONFIGURATION
//  CUSTOM_AXI_IP_SATURATE_EN defined: a lane whose add carries out is clamped to all-ones
//    and stays there for the rest of the run. ovf_o[l] is still set.
//  Undefined (default): modulo 2**DATA_WIDTH wrap-around. ovf_o[l] is set on each carry-out.
// TESTING
//  1. Reset asserted mid-BUSY -> all outputs 0 immediately, status_o=IDLE, no wen_o pulse after release.
//  2. lanes {0x10,0x05}, step 1, iter 3 -> BUSY 3 cycles, wen_o=1 one cycle, data {0x13,0x08}, ovf_o=00.
//  3. lane0=0xFFFF_FFFE, lane1=0, step 3, iter 1 -> lane0=0x0000_0001, lane1=3, ovf_o=01.
//     With SATURATE_EN: lane0=0xFFFF_FFFF.
//  4. enable_i with iter=0 -> ERROR for 1 cycle, wen_o stays 0, ipreg_data_o unchanged, then IDLE.
//  5. iter=10, abort_i pulsed in the 4th BUSY cycle -> ERROR next cycle, no wen_o, prior result held.
//  6. enable_i held high throughout -> BUSY runs are not restarted.
//     A new run is accepted on the first IDLE cycle after DONE, and ovf_o clears.

Source files
------------

// File: rtl/custom_axi_ip_engine_if.sv
// Status package and lane-engine bus interface; the engine takes the slave modport,
// the register side drives it through the master modport.
package custom_axi_ip_pkg;
    typedef enum logic [1:0] {
        StatusIdle  = 2'd0,
        StatusBusy  = 2'd1,
        StatusDone  = 2'd2,
        StatusError = 2'd3
    } status_e;
endpackage

interface custom_axi_ip_engine_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned ITER_W     = 8
) ();
    import custom_axi_ip_pkg::*;

    logic [NUM_LANES*DATA_WIDTH-1:0] ipreg_data_i;
    logic [DATA_WIDTH-1:0]           ipreg_step_i;
    logic [ITER_W-1:0]               ipreg_iter_i;
    logic                            enable_i;
    logic                            abort_i;
    logic [NUM_LANES*DATA_WIDTH-1:0] ipreg_data_o;
    logic                            wen_o;
    status_e                         status_o;
    logic                            busy_o;
    logic [NUM_LANES-1:0]            ovf_o;

    modport slave (
        input  ipreg_data_i, ipreg_step_i, ipreg_iter_i, enable_i, abort_i,
        output ipreg_data_o, wen_o, status_o, busy_o, ovf_o
    );

    modport master (
        output ipreg_data_i, ipreg_step_i, ipreg_iter_i, enable_i, abort_i,
        input  ipreg_data_o, wen_o, status_o, busy_o, ovf_o
    );
endinterface

// File: rtl/custom_axi_ip_engine.sv
// Multi-lane iterative adder: adds a common step to every lane for a programmed number of
// iterations and writes back once. Define CUSTOM_AXI_IP_SATURATE_EN to clamp lanes on carry-out.
module custom_axi_ip_engine
    import custom_axi_ip_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned ITER_W     = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    custom_axi_ip_engine_if.slave bus
);

    status_e                         state_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_q;
    logic [DATA_WIDTH-1:0]           step_q;
    logic [ITER_W-1:0]               cnt_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q;
    logic                            wen_q;
    logic [NUM_LANES-1:0]            ovf_q;

    logic [DATA_WIDTH:0]             ext [NUM_LANES];
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_d;
    logic [NUM_LANES-1:0]            carry;

    always_comb begin
        lane_d = '0;
        carry  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            ext[l]   = {1'b0, lane_q[l*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, step_q};
            carry[l] = ext[l][DATA_WIDTH];
`ifdef CUSTOM_AXI_IP_SATURATE_EN
            // A clamped lane carries again on any non-zero step, so it stays clamped.
            lane_d[l*DATA_WIDTH +: DATA_WIDTH] = carry[l] ? {DATA_WIDTH{1'b1}}
                                                          : ext[l][DATA_WIDTH-1:0];
`else
            lane_d[l*DATA_WIDTH +: DATA_WIDTH] = ext[l][DATA_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StatusIdle;
            lane_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            ovf_q   <= '0;
        end else begin
            wen_q <= 1'b0;
            case (state_q)
                StatusIdle: begin
                    if (bus.enable_i) begin
                        lane_q  <= bus.ipreg_data_i;
                        step_q  <= bus.ipreg_step_i;
                        cnt_q   <= bus.ipreg_iter_i;
                        ovf_q   <= '0;
                        state_q <= (bus.ipreg_iter_i == '0) ? StatusError : StatusBusy;
                    end
                end
                StatusBusy: begin
                    // Abort discards this cycle's add, including the final one.
                    if (bus.abort_i) begin
                        state_q <= StatusError;
                    end else begin
                        lane_q <= lane_d;
                        ovf_q  <= ovf_q | carry;
                        cnt_q  <= cnt_q - ITER_W'(1);
                        if (cnt_q == ITER_W'(1)) begin
                            state_q <= StatusDone;
                            wen_q   <= 1'b1;
                            data_q  <= lane_d;
                        end
                    end
                end
                StatusDone:  state_q <= StatusIdle;
                StatusError: state_q <= StatusIdle;
                default:     state_q <= StatusError;
            endcase
        end
    end

    assign bus.status_o     = state_q;
    assign bus.busy_o       = (state_q == StatusBusy);
    assign bus.wen_o        = wen_q;
    assign bus.ipreg_data_o = data_q;
    assign bus.ovf_o        = ovf_q;

endmodule
